// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and default datapath sizing.
package div_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_sub_stage.sv
// Trial subtractor for one restoring-division step. It is built as a
// ripple chain of full-adder cells fed with the inverted divisor and a
// carry-in of one, so a missing carry-out means the subtraction borrowed.
module div_sub_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] rem,
    input  logic [WIDTH:0] dvs,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    logic [WIDTH+1:0] carry;
    logic [WIDTH:0]   dvs_n;

    assign carry[0] = 1'b1;
    assign dvs_n    = ~dvs;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign diff[i]    = rem[i] ^ dvs_n[i] ^ carry[i];
        assign carry[i+1] = (rem[i] & dvs_n[i]) | (carry[i] & (rem[i] ^ dvs_n[i]));
    end

    assign borrow = ~carry[WIDTH+1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU. Operands are reduced to
// magnitudes at start, one quotient bit is produced per ITER cycle, and the
// signs are restored in a single FIX cycle that writes LO/HI.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div0
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   rem_q;
    logic             sign_q;
    logic             sign_r;
    logic             div0_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             rem_borrow;
    logic             start_div0;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Negative signed operands become their magnitude; the most negative
    // value wraps onto itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic is_signed,
                                             input logic [WIDTH-1:0] v);
        return (is_signed && v[WIDTH-1]) ? neg(v) : v;
    endfunction

    assign start_div0 = (i_divisor == '0);
    assign rem_shift  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

    div_sub_stage #(
        .WIDTH (WIDTH)
    ) u_sub (
        .rem    (rem_shift),
        .dvs    ({1'b0, dvs_q}),
        .diff   (rem_diff),
        .borrow (rem_borrow)
    );

    // Control FSM with iteration datapath and registered result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_div0      <= 1'b0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        // A zero divisor skips iteration; the raw dividend is
                        // kept so it can be returned unchanged as HI.
                        dvd_q  <= start_div0 ? i_dividend : mag(i_signed, i_dividend);
                        dvs_q  <= mag(i_signed, i_divisor);
                        rem_q  <= '0;
                        quo_q  <= '0;
                        sign_q <= i_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
                        sign_r <= i_signed & i_dividend[WIDTH-1];
                        div0_q <= start_div0;
                        cnt    <= CNT_W'(WIDTH);
                        o_busy <= 1'b1;
                        state  <= start_div0 ? FIX : ITER;
                    end
                end
                ITER: begin
                    rem_q <= rem_borrow ? rem_shift : rem_diff;
                    quo_q <= {quo_q[WIDTH-2:0], ~rem_borrow};
                    dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (div0_q) begin
                        o_quotient  <= '1;
                        o_remainder <= dvd_q;
                    end else begin
                        o_quotient  <= sign_q ? neg(quo_q) : quo_q;
                        o_remainder <= sign_r ? neg(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
                    end
                    o_div0 <= div0_q;
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases, handshake
// behaviour, mid-operation reset and randomized operands against an
// arithmetic reference model.
module tb_seq_divider;

    localparam int W = 32;

    logic         i_clk;
    logic         i_rst;
    logic         i_start;
    logic         i_signed;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div0;

    int checks;
    int failures;

    seq_divider #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_signed    (i_signed),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_div0      (o_div0)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // MIPS division semantics from plain integer arithmetic.
    task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa;
        longint sb;
        z = (b == 0);
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end
    endtask

    // Called just after a posedge; the request is accepted on the next edge.
    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        i_start    = 1'b1;
        i_signed   = s;
        i_dividend = a;
        i_divisor  = b;
        @(posedge i_clk);
        #1;
        i_start    = 1'b0;
        i_signed   = $urandom_range(0, 1);
        i_dividend = $urandom;
        i_divisor  = $urandom;
    endtask

    // Counts edges until o_done, checking latency and busy along the way.
    task automatic wait_done(input int exp_n, input string tag);
        int n;
        bit busy_ok;
        n = 0;
        busy_ok = 1'b1;
        while (n < 80) begin
            @(posedge i_clk);
            #1;
            n++;
            if (o_done) break;
            if (!o_busy) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, W'(n), W'(exp_n));
        check({tag, "_busy_during"}, W'(busy_ok), W'(1));
        check({tag, "_busy_at_done"}, W'(o_busy), W'(0));
    endtask

    task automatic check_result(input string tag, input logic s,
                                input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        model(s, a, b, q, r, z);
        check({tag, "_quot"}, o_quotient, q);
        check({tag, "_rem"}, o_remainder, r);
        check({tag, "_div0"}, W'(o_div0), W'(z));
    endtask

    task automatic do_op(input string tag, input logic s,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(s, a, b);
        wait_done((b == 0) ? 1 : 33, tag);
        check_result(tag, s, a, b);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q_hold;
        logic         s;
        int           done_seen;

        checks     = 0;
        failures   = 0;
        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_signed   = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_busy", W'(o_busy), W'(0));
        check("rst_done", W'(o_done), W'(0));
        check("rst_quot", o_quotient, '0);
        check("rst_rem", o_remainder, '0);
        check("rst_div0", W'(o_div0), W'(0));
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Directed values.
        do_op("u_100_7", 1'b0, 32'd100, 32'd7);
        check("u_100_7_abs_q", o_quotient, 32'd14);
        check("u_100_7_abs_r", o_remainder, 32'd2);
        do_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2);
        check("s_m7_2_abs_q", o_quotient, 32'hFFFF_FFFD);
        check("s_m7_2_abs_r", o_remainder, 32'hFFFF_FFFF);
        do_op("s_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE);
        check("s_7_m2_abs_q", o_quotient, 32'hFFFF_FFFD);
        check("s_7_m2_abs_r", o_remainder, 32'h1);
        do_op("s_div0", 1'b1, 32'h1234_5678, 32'h0);
        check("s_div0_abs_q", o_quotient, 32'hFFFF_FFFF);
        check("s_div0_abs_r", o_remainder, 32'h1234_5678);
        do_op("u_div0", 1'b0, 32'h1234_5678, 32'h0);
        check("u_div0_abs_flag", W'(o_div0), W'(1));
        do_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("s_ovf_abs_q", o_quotient, 32'h8000_0000);
        check("s_ovf_abs_r", o_remainder, 32'h0);
        do_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'h1);
        do_op("u_5_9", 1'b0, 32'd5, 32'd9);
        check("u_5_9_abs_q", o_quotient, 32'd0);
        do_op("s_min_m7", 1'b1, 32'h8000_0000, 32'hFFFF_FFF9);
        do_op("u_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Results persist in IDLE and the done pulse lasts one cycle.
        q_hold = o_quotient;
        repeat (3) @(posedge i_clk);
        #1;
        check("hold_quot", o_quotient, q_hold);
        check("hold_done_low", W'(o_done), W'(0));

        // Start during an active op is ignored.
        start_op(1'b0, 32'd1000, 32'd10);
        repeat (9) @(posedge i_clk);
        #1;
        i_start    = 1'b1;
        i_signed   = 1'b1;
        i_dividend = 32'd77;
        i_divisor  = 32'd3;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        wait_done(23, "ignore");
        check_result("ignore", 1'b0, 32'd1000, 32'd10);

        // Start in the done cycle is accepted and completes 33 edges later.
        start_op(1'b0, 32'd500, 32'd7);
        wait_done(33, "b2b_first");
        check_result("b2b_first", 1'b0, 32'd500, 32'd7);
        start_op(1'b1, 32'hFFFF_FC18, 32'd9);
        wait_done(33, "b2b_second");
        check_result("b2b_second", 1'b1, 32'hFFFF_FC18, 32'd9);

        // Reset in the middle of an operation aborts it.
        start_op(1'b0, 32'd123456, 32'd11);
        repeat (13) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("midrst_busy", W'(o_busy), W'(0));
        check("midrst_done", W'(o_done), W'(0));
        check("midrst_quot", o_quotient, '0);
        check("midrst_rem", o_remainder, '0);
        check("midrst_div0", W'(o_div0), W'(0));
        done_seen = 0;
        repeat (40) begin
            @(posedge i_clk);
            #1;
            if (o_done || o_busy) done_seen++;
        end
        check("midrst_no_done", W'(done_seen), W'(0));
        do_op("after_rst", 1'b0, 32'd123456, 32'd11);

        // Randomized operands, with small divisors and zero mixed in.
        for (int k = 0; k < 40; k++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = $urandom >> $urandom_range(0, 31);
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            do_op("rand", s, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
